// File: rtl/wave_pwm_multi_if.sv
// Config register bus into wave_pwm_multi: one write per cycle to one channel field.
interface wave_pwm_multi_if #(
  parameter int CW    = 2,
  parameter int ABITS = 24
);
  logic             cfg_we;
  logic [CW-1:0]    cfg_ch;
  logic [1:0]       cfg_sel;
  logic [ABITS-1:0] cfg_wdata;

  modport master (output cfg_we, cfg_ch, cfg_sel, cfg_wdata);
  modport slave  (input  cfg_we, cfg_ch, cfg_sel, cfg_wdata);
endinterface

// File: rtl/wave_pwm_multi.sv
// Multi-channel NCO-driven PWM generator with a shared frame counter and one shift-add duty engine.
// Optional WAVE_PWM_PHASE_SYNC_EN adds phase_sync, which clears all phases and the frame counter.
module wave_pwm_multi #(
  parameter  int CHANNELS = 4,
  parameter  int DBITS    = 16,
  parameter  int QBITS    = 8,
  parameter  int ABITS    = 24,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int OW       = $clog2(DBITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [OW-1:0]       div_sel,
  wave_pwm_multi_if.slave     cfg,
  input  logic                overrun_clr,
`ifdef WAVE_PWM_PHASE_SYNC_EN
  input  logic                phase_sync,
`endif
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_tick,
  output logic                busy,
  output logic                overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, MULT, STORE} state_t;

  logic [CHANNELS-1:0][ABITS-1:0] tune_q, off_q, acc_q;
  logic [CHANNELS-1:0][DBITS-1:0] amp_q, duty_sh_q, duty_act_q;
  logic [CHANNELS-1:0]            mode_q, pwm_q;
  logic [DBITS-1:0]               cnt_q;
  logic [DBITS:0]                 step, sum;
  logic                           tick_q, adv, sync;
  state_t                         st_q;
  logic [CW-1:0]                  ch_q;
  logic [OW-1:0]                  bit_q;
  logic [DBITS-1:0]               mplier_q;
  logic [2*DBITS-1:0]             mcand_q, prod_q;
  logic                           busy_q, ovr_q, pend_q;
  logic [QBITS-1:0]               taddr;
  logic [DBITS-1:0]               sample;

`ifdef WAVE_PWM_PHASE_SYNC_EN
  assign sync = enable & phase_sync;
`else
  assign sync = 1'b0;
`endif

  // Cos/sin wave table: unsigned offset-binary samples, folded to constants at elaboration.
  localparam int  TN = 1 << QBITS;
  localparam real PI = 3.14159265358979323846;
  localparam real FS = real'((1 << DBITS) - 1);
  logic [DBITS-1:0] cos_rom [TN];
  logic [DBITS-1:0] sin_rom [TN];
  for (genvar k = 0; k < TN; k++) begin : g_tbl
    localparam real ANG = 2.0 * PI * k / TN;
    assign cos_rom[k] = DBITS'($rtoi(FS * (1.0 + $cos(ANG)) / 2.0 + 0.5));
    assign sin_rom[k] = DBITS'($rtoi(FS * (1.0 + $sin(ANG)) / 2.0 + 0.5));
  end

  assign taddr  = QBITS'((acc_q[ch_q] + off_q[ch_q]) >> (ABITS - QBITS));
  assign sample = mode_q[ch_q] ? sin_rom[taddr] : cos_rom[taddr];

  assign step = (DBITS+1)'(1) << div_sel;
  assign sum  = {1'b0, cnt_q} + step;
  assign adv  = enable & tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tune_q <= '0;
      off_q  <= '0;
      amp_q  <= '0;
      mode_q <= '0;
    end else if (cfg.cfg_we && (32'(cfg.cfg_ch) < CHANNELS)) begin
      case (cfg.cfg_sel)
        2'd0: tune_q[cfg.cfg_ch] <= cfg.cfg_wdata;
        2'd1: amp_q[cfg.cfg_ch]  <= cfg.cfg_wdata[DBITS-1:0];
        2'd2: off_q[cfg.cfg_ch]  <= cfg.cfg_wdata;
        2'd3: mode_q[cfg.cfg_ch] <= cfg.cfg_wdata[0];
      endcase
    end
  end

  // Tick is raised the cycle after the carry, so the frame restarts from cnt 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (enable) begin
      cnt_q  <= sync ? '0 : sum[DBITS-1:0];
      tick_q <= sum[DBITS] & ~sync;
    end else begin
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      duty_act_q <= '0;
      pwm_q      <= '0;
    end else begin
      if (sync) begin
        acc_q <= '0;
      end else if (adv) begin
        for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_q[c] + tune_q[c];
        duty_act_q <= duty_sh_q;
      end
      for (int c = 0; c < CHANNELS; c++) pwm_q[c] <= enable && (cnt_q < duty_act_q[c]);
    end
  end

  // Duty engine; a tick while still busy restarts at channel 0 and flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      ch_q      <= '0;
      bit_q     <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      duty_sh_q <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      if (overrun_clr) ovr_q <= 1'b0;
      if (enable) begin
        pend_q <= sync;
        if (sync) begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
        end else if (adv || pend_q) begin
          if (adv && st_q != IDLE) ovr_q <= 1'b1;
          st_q   <= FETCH;
          ch_q   <= '0;
          busy_q <= 1'b1;
        end else begin
          case (st_q)
            FETCH: begin
              mcand_q  <= {{DBITS{1'b0}}, sample};
              mplier_q <= amp_q[ch_q];
              prod_q   <= '0;
              bit_q    <= '0;
              st_q     <= MULT;
            end
            MULT: begin
              if (mplier_q[0]) prod_q <= prod_q + mcand_q;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
              bit_q    <= bit_q + 1'b1;
              if (bit_q == OW'(DBITS-1)) st_q <= STORE;
            end
            STORE: begin
              duty_sh_q[ch_q] <= prod_q[2*DBITS-1:DBITS];
              if (32'(ch_q) == CHANNELS-1) begin
                st_q   <= IDLE;
                busy_q <= 1'b0;
              end else begin
                ch_q <= ch_q + 1'b1;
                st_q <= FETCH;
              end
            end
            default: st_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_wave_pwm_multi.sv
// Directed/randomized bench for wave_pwm_multi (CHANNELS=4, DBITS=8, QBITS=6, ABITS=12).
module tb_wave_pwm_multi;
  localparam int CH = 4, DB = 8, QB = 6, AB = 12;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, overrun_clr = 1'b0;
  logic [2:0]    div_sel = '0;
  logic [CH-1:0] pwm_out;
  logic          frame_tick, busy, overrun;
`ifdef WAVE_PWM_PHASE_SYNC_EN
  logic          phase_sync = 1'b0;
`endif

  wave_pwm_multi_if #(.CW(2), .ABITS(AB)) cfg_if ();

  wave_pwm_multi #(.CHANNELS(CH), .DBITS(DB), .QBITS(QB), .ABITS(AB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div_sel(div_sel), .cfg(cfg_if),
    .overrun_clr(overrun_clr),
`ifdef WAVE_PWM_PHASE_SYNC_EN
    .phase_sync(phase_sync),
`endif
    .pwm_out(pwm_out), .frame_tick(frame_tick), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int tune [CH], amp [CH], off [CH], mode [CH];
  int hi [CH];
  int bz, tk_at;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: table value is the ideal raised cosine/sine rounded to 8 bits.
  function automatic int tbl(int m, int a);
    real ang, v;
    ang = 2.0 * 3.14159265358979323846 * a / 64;
    v = (m != 0) ? $sin(ang) : $cos(ang);
    return $rtoi(255.0 * (1.0 + v) / 2.0 + 0.5);
  endfunction

  // Duty computed after the accumulator has absorbed n tuning steps.
  function automatic int duty(int c, int n);
    int ph;
    ph = (n * tune[c] + off[c]) % 4096;
    return (tbl(mode[c], ph / 64) * amp[c]) / 256;
  endfunction

  // High cycles per frame: counter values (multiples of the step) below duty.
  function automatic int hexp(int d, int s);
    int n = 0;
    for (int k = 0; k < (256 >> s); k++) if ((k << s) < d) n++;
    return n;
  endfunction

  task automatic wr(int c, int sel, int data);
    @(negedge clk);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_ch    = 2'(c);
    cfg_if.cfg_sel   = 2'(sel);
    cfg_if.cfg_wdata = 12'(data);
    @(negedge clk);
    cfg_if.cfg_we    = 1'b0;
  endtask

  task automatic cfg_all();
    for (int c = 0; c < CH; c++) begin
      wr(c, 0, tune[c]); wr(c, 1, amp[c]); wr(c, 2, off[c]); wr(c, 3, mode[c]);
    end
  endtask

  task automatic sync_tick(int lim);
    int n = 0;
    while (frame_tick !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    check("sync_tick", int'(frame_tick), 1);
    @(negedge clk);
  endtask

  task automatic window(int len);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    bz = 0; tk_at = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      bz += int'(busy);
      if (frame_tick === 1'b1) tk_at = i;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; enable = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_sel = '0; cfg_if.cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst pwm_out", int'(pwm_out), 0);
    check("rst frame_tick", int'(frame_tick), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    rst = 1'b0;

    // All amplitudes zero: outputs stay low, engine runs 40 cycles per frame.
    enable = 1'b1;
    sync_tick(300);
    for (int f = 0; f < 2; f++) begin
      window(256);
      for (int c = 0; c < CH; c++) check($sformatf("zero f%0d ch%0d", f, c), hi[c], 0);
      check("zero busy cycles", bz, 40);
      check("zero tick period", tk_at, 254);
    end

    // Randomized channels against the frame-level model for 70 frames.
    do_reset();
    tune[0] = 0;  amp[0] = 255; off[0] = 0; mode[0] = 0;
    tune[1] = 64; amp[1] = $urandom_range(255, 1); off[1] = $urandom_range(4095, 0);
    mode[1] = $urandom_range(1, 0);
    for (int c = 2; c < CH; c++) begin
      tune[c] = $urandom_range(4095, 0); amp[c] = $urandom_range(255, 0);
      off[c]  = $urandom_range(4095, 0); mode[c] = $urandom_range(1, 0);
    end
    cfg_all();
    enable = 1'b1;
    sync_tick(300);
    for (int k = 1; k <= 70; k++) begin
      window(256);
      for (int c = 0; c < CH; c++)
        check($sformatf("duty k%0d ch%0d", k, c), hi[c], (k == 1) ? 0 : duty(c, k - 1));
      check($sformatf("busy k%0d", k), bz, 40);
      check($sformatf("tick k%0d", k), tk_at, 254);
    end
    check("full-scale ch0", duty(0, 1), 254);

    // Reset in the middle of a multiply.
    repeat (3) @(negedge clk);
    check("mid-mult busy", int'(busy), 1);
    rst = 1'b1; enable = 1'b0;
    #1;
    check("async rst pwm_out", int'(pwm_out), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst tick", int'(frame_tick), 0);
    check("async rst overrun", int'(overrun), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post rst idle", int'(busy), 0);

    // 32-cycle frames cannot fit the 40-cycle engine: channel 3 never lands.
    for (int c = 0; c < CH; c++) begin
      tune[c] = 0; off[c] = 0; mode[c] = 0; amp[c] = $urandom_range(255, 32);
    end
    amp[1] = 0;
    cfg_all();
    div_sel = 3'd3;
    enable  = 1'b1;
    sync_tick(60);
    check("overrun after first tick", int'(overrun), 0);
    for (int k = 1; k <= 5; k++) begin
      window(32);
      check($sformatf("ovr ch0 k%0d", k), hi[0], (k == 1) ? 0 : hexp(duty(0, 0), 3));
      check($sformatf("ovr ch1 k%0d", k), hi[1], 0);
      check($sformatf("ovr ch2 k%0d", k), hi[2], (k == 1) ? 0 : hexp(duty(2, 0), 3));
      check($sformatf("ovr ch3 k%0d", k), hi[3], 0);
      check($sformatf("ovr tick k%0d", k), tk_at, 30);
      check($sformatf("overrun k%0d", k), int'(overrun), 1);
    end
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    check("overrun_clr clears", int'(overrun), 0);
    begin
      int n = 0;
      while (frame_tick !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("clr tick found", int'(frame_tick), 1);
      overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      check("set beats clr", int'(overrun), 1);
    end

`ifdef WAVE_PWM_PHASE_SYNC_EN
    do_reset();
    div_sel = 3'd0;
    tune[0] = 64; amp[0] = 255; off[0] = 0; mode[0] = 0;
    cfg_all();
    enable = 1'b1;
    sync_tick(300);
    repeat (4) @(negedge clk);
    check("pre-sync busy", int'(busy), 1);
    phase_sync = 1'b1;
    @(negedge clk); phase_sync = 1'b0;
    check("sync busy idle", int'(busy), 0);
    check("sync cnt cleared", int'(dut.cnt_q), 0);
    check("sync acc cleared", int'(dut.acc_q[0]), 0);
    @(negedge clk);
    check("sync restart busy", int'(busy), 1);
    check("sync no overrun", int'(overrun), 0);
    begin
      int n = 2;
      while (frame_tick !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("sync next tick", n, 257);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
